// File: rtl/ov7670_sccb_config.sv
// OV7670 SCCB register-table writer: walks a synchronous {reg,val} ROM and issues 3-phase writes.
// Define SCCB_ACK_CHECK_EN to abort the table when SIOD reads high in a don't-care slot.
module ov7670_sccb_config #(
   parameter logic [7:0] DEV_ADDR     = 8'h42,
   parameter int         QUARTER_DIV  = 125,
   parameter int         DELAY_CYCLES = 500000,
   parameter int         ADDR_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic              sioc,
   output logic              siod_oe,
   input  logic              siod_in,
   output logic              busy,
   output logic              done,
   output logic              err
);
   localparam int QW = $clog2(QUARTER_DIV + 1);
   localparam int DW = $clog2(DELAY_CYCLES + 1);
   localparam logic [QW-1:0] QMAX = QW'(QUARTER_DIV - 1);
   localparam logic [DW-1:0] DMAX = DW'(DELAY_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_START, S_BITS, S_STOP, S_GAP, S_DELAY
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [QW-1:0]     qcnt_q, qcnt_d;
   logic [DW-1:0]     dcnt_q, dcnt_d;
   logic [1:0]        quarter_q, quarter_d;
   logic [4:0]        slot_q, slot_d;
   logic [26:0]       frame_q, frame_d;
   logic              sioc_q, sioc_d;
   logic              oe_q, oe_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              nak_q, nak_d;

   logic sccb_active, tick, dc_slot, nak_hit, advance;

   assign sccb_active = (state_q == S_START) || (state_q == S_BITS) ||
                        (state_q == S_STOP)  || (state_q == S_GAP);
   assign tick        = sccb_active && (qcnt_q == QMAX);
   assign dc_slot     = (slot_q == 5'd8) || (slot_q == 5'd17) || (slot_q == 5'd26);

`ifdef SCCB_ACK_CHECK_EN
   // Slave ACK is sampled late in the high half of the don't-care slot.
   assign nak_hit = (state_q == S_BITS) && tick && dc_slot && (quarter_q == 2'd2) && siod_in;
`else
   logic unused_siod;
   assign unused_siod = siod_in;
   assign nak_hit     = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      qcnt_d    = '0;
      dcnt_d    = '0;
      quarter_d = tick ? quarter_q + 2'd1 : quarter_q;
      slot_d    = slot_q;
      frame_d   = frame_q;
      sioc_d    = 1'b1;
      oe_d      = 1'b0;
      busy_d    = busy_q;
      done_d    = done_q;
      err_d     = err_q;
      nak_d     = nak_q;
      advance   = 1'b0;

      if (sccb_active && !tick) qcnt_d = qcnt_q + QW'(1);

      case (state_q)
         S_IDLE: begin
            quarter_d = 2'd0;
            nak_d     = 1'b0;
            if (start) begin
               addr_d  = '0;
               done_d  = 1'b0;
               err_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            quarter_d = 2'd0;
            slot_d    = 5'd0;
            if (rom_data == 16'hFFFF) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else if (rom_data[15:8] == 8'hF0) begin
               state_d = S_DELAY;
            end else begin
               // Don't-care slots carry 1 so the bus is released for the slave ACK.
               frame_d = {DEV_ADDR, 1'b1, rom_data[15:8], 1'b1, rom_data[7:0], 1'b1};
               state_d = S_START;
            end
         end
         S_START: begin
            oe_d = quarter_q[1];
            if (tick && quarter_q == 2'd3) state_d = S_BITS;
         end
         S_BITS: begin
            sioc_d = quarter_q[1];
            oe_d   = dc_slot ? 1'b0 : ~frame_q[26];
            if (nak_hit) begin
               nak_d     = 1'b1;
               quarter_d = 2'd0;
               state_d   = S_STOP;
            end else if (tick && quarter_q == 2'd3) begin
               slot_d  = slot_q + 5'd1;
               frame_d = {frame_q[25:0], 1'b0};
               if (slot_q == 5'd26) state_d = S_STOP;
            end
         end
         S_STOP: begin
            sioc_d = quarter_q[1];
            oe_d   = (quarter_q != 2'd3);
            if (tick && quarter_q == 2'd3) begin
               if (nak_q) begin
                  nak_d   = 1'b0;
                  err_d   = 1'b1;
                  busy_d  = 1'b0;
                  done_d  = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (tick && quarter_q == 2'd3) advance = 1'b1;
         end
         S_DELAY: begin
            dcnt_d = dcnt_q + DW'(1);
            if (dcnt_q == DMAX) advance = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // The last ROM slot finishes the table instead of wrapping the address.
      if (advance) begin
         if (&addr_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_FETCH;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         qcnt_q    <= '0;
         dcnt_q    <= '0;
         quarter_q <= 2'd0;
         slot_q    <= 5'd0;
         sioc_q    <= 1'b1;
         oe_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         nak_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         qcnt_q    <= qcnt_d;
         dcnt_q    <= dcnt_d;
         quarter_q <= quarter_d;
         slot_q    <= slot_d;
         sioc_q    <= sioc_d;
         oe_q      <= oe_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         nak_q     <= nak_d;
      end
   end

   always_ff @(posedge clk) begin
      frame_q <= frame_d;
   end

   assign rom_addr = addr_q;
   assign sioc     = sioc_q;
   assign siod_oe  = oe_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Scoreboard bench for ov7670_sccb_config: a bus monitor decodes SCCB frames and run ends.
`timescale 1ns/1ps
module tb_ov7670_sccb_config;
   localparam int QD = 2;
   localparam int DC = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        nack_mode = 1'b0;
   logic        siod_in;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data;
   logic        sioc, siod_oe, busy, done, err;
   logic [15:0] rom [0:255];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;
   assign siod_in = nack_mode;
   always @(posedge clk) rom_data <= rom[rom_addr];

   ov7670_sccb_config #(
      .DEV_ADDR(8'h42), .QUARTER_DIV(QD), .DELAY_CYCLES(DC), .ADDR_W(8)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
      .sioc(sioc), .siod_oe(siod_oe), .siod_in(siod_in),
      .busy(busy), .done(done), .err(err)
   );

   typedef struct {int nbits; logic [31:0] bits; int lat;} frame_t;
   typedef struct {int len; logic done; logic err; logic [7:0] addr;} end_t;
   frame_t exp_f[$];
   end_t   exp_e[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic push_write(input logic [7:0] r, input logic [7:0] v, input int lat);
      frame_t f;
      f.nbits = 28;
      f.bits  = {4'b0, 8'h42, 1'b1, r, 1'b1, v, 1'b1, 1'b0};
      f.lat   = lat;
      exp_f.push_back(f);
   endtask

   task automatic push_end(input int len, input logic d, input logic e, input logic [7:0] a);
      end_t x;
      x.len = len; x.done = d; x.err = e; x.addr = a;
      exp_e.push_back(x);
   endtask

   task automatic load3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
      for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
      rom[0] = a; rom[1] = b; rom[2] = c;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int maxc);
      int c = 0;
      while (busy && c < maxc) begin
         @(negedge clk);
         c++;
      end
      if (busy) begin
         n_checks++;
         n_fail++;
         $display("FAIL run_timeout: busy still 1 after %0d cycles", maxc);
      end
      repeat (4) @(negedge clk);
   endtask

   // Bus monitor: frames are bounded by start/stop conditions, bits taken on SIOC rises.
   logic        sioc_p = 1'b1, oe_p = 1'b0, busy_p = 1'b0, in_frame = 1'b0;
   int          run_cyc = 0, nbits = 0, idle_low = 0, lat = 0;
   logic [31:0] bits = '0;
   frame_t      ef;
   end_t        ee;

   initial begin
      forever begin
         @(negedge clk);
         if (busy) begin
            if (!busy_p) begin
               run_cyc  = 0;
               idle_low = 0;
            end else begin
               run_cyc++;
            end
         end
         if (rst) begin
            in_frame = 1'b0;
         end else if (!in_frame && sioc_p && sioc && !oe_p && siod_oe) begin
            in_frame = 1'b1;
            nbits    = 0;
            bits     = '0;
            lat      = run_cyc;
         end else if (in_frame && !sioc_p && sioc) begin
            bits = {bits[30:0], ~siod_oe};
            nbits++;
         end else if (in_frame && sioc_p && sioc && oe_p && !siod_oe) begin
            in_frame = 1'b0;
            if (exp_f.size() == 0) begin
               check("unexpected_frame", 32'(nbits), 32'(0));
            end else begin
               ef = exp_f.pop_front();
               check("frame_nbits", 32'(nbits), 32'(ef.nbits));
               check("frame_bits", bits, ef.bits);
               check("frame_latency", 32'(lat), 32'(ef.lat));
            end
         end
         if (busy && !in_frame && !sioc) idle_low++;
         if (busy_p && !busy) begin
            if (exp_e.size() == 0) begin
               check("unexpected_run_end", 32'(run_cyc + 1), 32'(0));
            end else begin
               ee = exp_e.pop_front();
               check("busy_cycles", 32'(run_cyc + 1), 32'(ee.len));
               check("end_done", 32'(done), 32'(ee.done));
               check("end_err", 32'(err), 32'(ee.err));
               check("end_rom_addr", 32'(rom_addr), 32'(ee.addr));
               check("sioc_low_outside_frame", 32'(idle_low), 32'(0));
            end
         end
         sioc_p = sioc;
         oe_p   = siod_oe;
         busy_p = busy;
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      load3(16'hFFFF, 16'hFFFF, 16'hFFFF);
      repeat (3) @(negedge clk);
      check("rst_sioc", 32'(sioc), 32'(1));
      check("rst_siod_oe", 32'(siod_oe), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_err", 32'(err), 32'(0));
      check("rst_rom_addr", 32'(rom_addr), 32'(0));
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Single write, with a start pulse mid-run that must be ignored.
      load3(16'h1280, 16'hFFFF, 16'hFFFF);
      push_write(8'h12, 8'h80, 7);
      push_end(244, 1'b1, 1'b0, 8'd1);
      pulse_start();
      repeat (100) @(negedge clk);
      pulse_start();
      wait_idle(2000);
      check("done_held", 32'(done), 32'(1));

      // Delay entry, then one write.
      load3(16'hF000, 16'h1101, 16'hFFFF);
      push_write(8'h11, 8'h01, 29);
      push_end(266, 1'b1, 1'b0, 8'd2);
      pulse_start();
      wait_idle(2000);

      // Two back-to-back writes: second frame one full entry period later.
      load3(16'h3A04, 16'h4010, 16'hFFFF);
      push_write(8'h3A, 8'h04, 7);
      push_write(8'h40, 8'h10, 249);
      push_end(486, 1'b1, 1'b0, 8'd2);
      pulse_start();
      wait_idle(2000);

      // Reset during the tenth bit slot, then a clean restart from entry 0.
      load3(16'h1280, 16'hFFFF, 16'hFFFF);
      push_end(85, 1'b0, 1'b0, 8'd0);
      pulse_start();
      repeat (84) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_sioc", 32'(sioc), 32'(1));
      check("midrst_siod_oe", 32'(siod_oe), 32'(0));
      check("midrst_busy", 32'(busy), 32'(0));
      check("midrst_rom_addr", 32'(rom_addr), 32'(0));
      rst = 1'b0;
      repeat (3) @(negedge clk);
      push_write(8'h12, 8'h80, 7);
      push_end(244, 1'b1, 1'b0, 8'd1);
      pulse_start();
      wait_idle(2000);

      // SIOD held high in the ACK slots.
      nack_mode = 1'b1;
      load3(16'h1280, 16'hFFFF, 16'hFFFF);
`ifdef SCCB_ACK_CHECK_EN
      begin
         frame_t f;
         f.nbits = 10;
         f.bits  = {22'b0, 8'h42, 1'b1, 1'b0};
         f.lat   = 7;
         exp_f.push_back(f);
      end
      push_end(88, 1'b0, 1'b1, 8'd0);
`else
      push_write(8'h12, 8'h80, 7);
      push_end(244, 1'b1, 1'b0, 8'd1);
`endif
      pulse_start();
      wait_idle(2000);
      nack_mode = 1'b0;

      repeat (5) @(negedge clk);
      check("frames_pending", 32'(exp_f.size()), 32'(0));
      check("run_ends_pending", 32'(exp_e.size()), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
